// File: rtl/RSA_pkg.sv
// -----------------------------------------------------------------------------
// RSA_pkg
// Shared types for the RSAMont core and its word-serial bridge.
//   MOD_WIDTH      modulus / operand width in bits
//   KeyType        one MOD_WIDTH-bit operand
//   RSAMontModIn   packed request operands {base, msg, key, modulus}
//   RSAMontModOut  packed response {result}
//   WORD_WIDTH     default host stream word width
//   N_WORDS        words per operand at the default word width
//   N_FIELDS       operands per request
//   bridge_state_e word bridge FSM states
// -----------------------------------------------------------------------------
package RSA_pkg;

  localparam int MOD_WIDTH = 256;

  typedef logic [MOD_WIDTH-1:0] KeyType;

  typedef struct packed {
    KeyType base;
    KeyType msg;
    KeyType key;
    KeyType modulus;
  } RSAMontModIn;

  typedef struct packed {
    KeyType result;
  } RSAMontModOut;

  localparam int WORD_WIDTH = 32;
  localparam int N_WORDS    = MOD_WIDTH / WORD_WIDTH;
  localparam int N_FIELDS   = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/rsa_word_unpacker.sv
// -----------------------------------------------------------------------------
// rsa_word_unpacker
// Captures a wide result and streams it out least-significant word first over
// a valid/ready interface. o_last marks the final word; done pulses on the
// handshake of that word.
//   clk, rst    clock, asynchronous active-low reset
//   load        capture load_data and start streaming next cycle
//   load_data   WORD_WIDTH*N_WORDS-bit value to stream
//   o_valid     output word valid
//   o_ready     downstream ready
//   o_word      current output word
//   o_last      high on the final word
//   done        final word handshake taking place this cycle
// -----------------------------------------------------------------------------
module rsa_word_unpacker #(
  parameter int WORD_WIDTH = 32,
  parameter int N_WORDS    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [WORD_WIDTH*N_WORDS-1:0]  load_data,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [WORD_WIDTH-1:0]          o_word,
  output logic                           o_last,
  output logic                           done
);

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  logic [WORD_WIDTH*N_WORDS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          active_q, active_d;
  logic                          fire;

  assign o_valid = active_q;
  // The shift register is zero outside a burst, so o_word idles at 0.
  assign o_word  = shift_q[WORD_WIDTH-1:0];
  assign o_last  = active_q && (cnt_q == LAST_IDX);
  assign fire    = active_q && o_ready;
  assign done    = fire && o_last;

  // NOTE: every combinational output gets its default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      shift_d  = load_data;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (fire) begin
      shift_d = shift_q >> WORD_WIDTH;
      if (o_last) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/rsa_word_bridge.sv
// -----------------------------------------------------------------------------
// rsa_word_bridge
// Word-serial host front-end for the RSAMont core. Collects base, msg, key and
// modulus (each LS word first), issues one request, waits for the result and
// streams it back LS word first. One job in flight.
//   clk, rst                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_word   input word stream
//   m_valid/m_ready/m_in     request to RSAMont
//   r_valid/r_ready/r_out    response from RSAMont
//   o_valid/o_ready/o_word/o_last  output word stream
//   o_cycles                 cycles spent waiting for the last response
// Optional: define RSA_BRIDGE_PERF_EN to build the o_cycles latency counter;
// otherwise o_cycles is tied to 0.
// -----------------------------------------------------------------------------
module rsa_word_bridge
  import RSA_pkg::MOD_WIDTH, RSA_pkg::KeyType, RSA_pkg::RSAMontModIn,
         RSA_pkg::RSAMontModOut, RSA_pkg::N_FIELDS, RSA_pkg::bridge_state_e,
         RSA_pkg::LOAD, RSA_pkg::REQ, RSA_pkg::WAIT, RSA_pkg::SEND;
#(
  parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_word,
  output logic                  m_valid,
  input  logic                  m_ready,
  output RSAMontModIn           m_in,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  RSAMontModOut          r_out,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_last,
  output logic [31:0]           o_cycles
);

  localparam int N_WORDS = MOD_WIDTH / WORD_WIDTH;
  localparam int WCNT_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(N_WORDS - 1);
  localparam logic [1:0]        LAST_FIELD = 2'(N_FIELDS - 1);

  bridge_state_e     state_q, state_d;
  logic [WCNT_W-1:0] word_q, word_d;
  logic [1:0]        field_q, field_d;
  KeyType            ops_q [N_FIELDS];

  logic s_fire, m_fire, r_fire, send_done;

  // Handshake strobes depend only on registered state, so m_valid rises the
  // cycle after the last input word is accepted.
  assign s_ready = (state_q == LOAD);
  assign m_valid = (state_q == REQ);
  assign r_ready = (state_q == WAIT);

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;
  assign r_fire = r_valid && r_ready;

  assign m_in.base    = ops_q[0];
  assign m_in.msg     = ops_q[1];
  assign m_in.key     = ops_q[2];
  assign m_in.modulus = ops_q[3];

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    field_d = field_q;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            field_d = field_q + 1'b1;
            if (field_q == LAST_FIELD) state_d = REQ;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      REQ:  if (m_fire) state_d = WAIT;
      WAIT: begin
        if (r_fire) begin
          word_d  = '0;
          state_d = SEND;
        end
      end
      SEND:    if (send_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      word_q  <= '0;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      field_q <= field_d;
    end
  end

  // NOTE: the operand store is cleared on reset because reset must present
  // all stored operands as 0 on m_in; a storage array that is only read
  // after being fully written would normally skip the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < N_FIELDS; f++) ops_q[f] <= '0;
    end else if (s_fire) begin
      ops_q[field_q][word_q*WORD_WIDTH +: WORD_WIDTH] <= s_word;
    end
  end

  rsa_word_unpacker #(
    .WORD_WIDTH (WORD_WIDTH),
    .N_WORDS    (N_WORDS)
  ) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (r_fire),
    .load_data (r_out.result),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_word    (o_word),
    .o_last    (o_last),
    .done      (send_done)
  );

`ifdef RSA_BRIDGE_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // Cleared when a request is accepted, counts WAIT cycles, saturates, and
  // holds its value until the next request.
  always_comb begin
    cycles_d = cycles_q;
    if (m_fire) begin
      cycles_d = '0;
    end else if ((state_q == WAIT) && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycles_q <= '0;
    else      cycles_q <= cycles_d;
  end

  assign o_cycles = cycles_q;
`else
  assign o_cycles = '0;
`endif

endmodule
